// File: rtl/a0_trace_fifo_if.sv
// rtl/a0_trace_fifo_if.sv - drain-side valid/ready stream of the a0 trace FIFO
//
// Signals:
//   out_valid  head entry available (driven by the FIFO)
//   out_ready  consumer accepts the head entry (driven by the consumer)
//   out_data   head entry a0 value
//   out_ts     head entry capture timestamp (0 when timestamps are disabled)
// Modports: master = FIFO side, slave = consumer side.

interface a0_trace_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TS_WIDTH   = 16
) ();

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [TS_WIDTH-1:0]   out_ts;

  modport master (
    output out_valid,
    input  out_ready,
    output out_data,
    output out_ts
  );

  modport slave (
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_ts
  );

endinterface

// File: rtl/a0_trace_fifo.sv
// rtl/a0_trace_fifo.sv - change-detecting a0 capture FIFO with optional timestamps
//
// Samples the CPU a0 output every cycle while en=1 and pushes each new value into
// a first-word-fall-through FIFO drained over a valid/ready stream.
//
// Optional feature macro: A0_TRACE_TIMESTAMP_EN
//   defined     -> free-running cycle counter, each entry also stores its capture
//                  timestamp, out_ts carries it
//   not defined -> no counter, no timestamp storage, out_ts tied to 0
//
// Ports:
//   clk           clock, all state updates on rising edge
//   rst           synchronous active-high reset (overrides everything)
//   en            capture enable
//   a0            a0 value from the CPU top
//   trace         drain stream (a0_trace_fifo_if.master): out_valid/out_ready/
//                 out_data/out_ts
//   count         entries held, 0..DEPTH
//   overflow      sticky flag, set when a push had to be dropped
//   clr_overflow  clears overflow (a same-cycle drop wins)

module a0_trace_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int TS_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [DATA_WIDTH-1:0]    a0,
  a0_trace_fifo_if.master          trace,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clr_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] prev;
  logic                  prev_valid;

  logic push_req;
  logic pop;
  logic full;
  logic push_ok;
  logic drop;

  // A value is new if nothing has been sampled since reset or it differs from
  // the last sample; repeats of the same value are not traced.
  assign push_req = en && (!prev_valid || (a0 != prev));
  assign pop      = (count != '0) && trace.out_ready;
  assign full     = (count == CW'(DEPTH));
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && !push_ok;

  assign trace.out_valid = (count != '0);
  assign trace.out_data  = data_mem[rd_ptr];

`ifdef A0_TRACE_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt;
  logic [TS_WIDTH-1:0] ts_mem [DEPTH];

  assign trace.out_ts = ts_mem[rd_ptr];

  // Reads 0 in the first cycle after reset and wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      ts_mem[wr_ptr] <= ts_cnt;
    end
  end
`else
  assign trace.out_ts = '0;
`endif

  // Storage is not reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      data_mem[wr_ptr] <= a0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      prev       <= '0;
      prev_valid <= 1'b0;
    end else begin
      // prev tracks the input even when the push is dropped, so a value that
      // was lost to overflow is not retried on the following cycles.
      if (en) begin
        prev       <= a0;
        prev_valid <= 1'b1;
      end

      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end

      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule
